fp_out_sched: RTL and testbench
===============================

Name: fp_out_sched

Overview:
Round-robin scheduler that shares the single serial output register between NUM_REQ result producers, such as FP adder lanes. It takes a 32-bit result from a requester and writes it into the output register. It then drives the register's read strobe for exactly 32 shift cycles and waits until the register is ready for input again. It sits between the adder result stage and the output register.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
SRC_W, 1, width of source id, equal to clog2(NUM_REQ)
WAIT_TIMEOUT, 15, maximum cycles in WAIT_RDY before the error flag is set

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset; asynchronous, active-high
req_valid_in  input  NUM_REQ  per-requester result valid; held until acked
req_data_in  input  32*NUM_REQ  requester k result in bits [32k+31:32k]
req_ack_out  output  NUM_REQ  one-cycle grant/acknowledge pulse, one-hot
stream_en_in  input  1  host permits shifting this cycle
reg_input_rdy_in  input  1  output register input_rdy
reg_output_rdy_in  input  1  output register output_rdy
reg_wr_out  output  1  output register write enable
reg_data_out  output  32  output register parallel data
reg_read_out  output  1  output register serial read strobe
src_id_out  output  SRC_W  index of the requester whose word is in flight
busy_out  output  1  state is not IDLE
frame_done_out  output  1  one-cycle pulse when a word has been fully shifted out
err_out  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE.
  - All outputs 0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - bit_cnt=0, timeout counter=0.
  - Reset mid-frame abandons the frame with no done pulse.
- IDLE:
  - Condition: reg_input_rdy_in=1 and any req_valid_in set.
  - Grant g = first valid index searched from rr_ptr+1, wrapping modulo NUM_REQ.
  - Registered on that edge: req_ack_out[g]=1 for one cycle, reg_data_out=word g, src_id_out=g, rr_ptr=g.
  - Go to WRITE.
  - If reg_input_rdy_in=0, stay in IDLE and grant nothing.
- WRITE:
  - reg_wr_out=1 for exactly one cycle.
  - reg_data_out is held stable.
  - Go to WAIT_RDY.
- WAIT_RDY:
  - Wait for reg_output_rdy_in=1, then go to SHIFT with bit_cnt=0.
  - Timeout counter increments each cycle in this state.
  - If the counter reaches WAIT_TIMEOUT: set err_out, go to IDLE, no frame_done pulse.
- SHIFT:
  - reg_read_out = (state==SHIFT) && stream_en_in && (bit_cnt<32). This is combinational, with no added latency.
  - bit_cnt increments on each cycle with reg_read_out=1.
  - stream_en_in=0 pauses shifting; bit_cnt holds and the pause is unbounded.
  - When bit_cnt reaches 32, go to DRAIN. Exactly 32 read cycles are issued per word.
- DRAIN:
  - reg_read_out=0.
  - Wait for reg_input_rdy_in=1.
  - Then pulse frame_done_out for one cycle (src_id_out still valid) and go to IDLE.
  - Back-to-back: a new grant may occur in the cycle after the return to IDLE.
- Latency and ordering:
  - Best case from valid to first read strobe is 4 cycles: ack edge, WRITE, WAIT_RDY, SHIFT.
  - req_valid_in sampled outside IDLE is ignored.
  - A requester that deasserts valid before being acked loses its turn with no error.
- Arithmetic:
  - bit_cnt is 6 bits and saturates at 32.
  - Timeout counter is clog2(WAIT_TIMEOUT+1) bits.
  - rr_ptr wraps modulo NUM_REQ; non-power-of-2 NUM_REQ must wrap correctly.
- Only one outstanding word; the block never issues a write while the register is not input-ready.

Decomposition:
- Shared package fp_pkg holds:
  - state enum constants: IDLE, WRITE, WAIT_RDY, SHIFT, DRAIN
  - WORD_W=32 and SHIFT_LEN=32
- Sub-module rr_arbiter (parameter N): inputs are the request vector and last-grant pointer; outputs are a one-hot grant and its index. It is purely combinational and reusable by the input-side schedulers.

Test Plan:
1. Single requester: req0 valid with 0x3F800000, stream_en=1, register model attached. Expect ack0 at cycle 1, wr at cycle 2, 32 read strobes, serial bits LSB-first matching 0x3F800000, then one frame_done pulse.
2. Fairness: req0 and req1 both held valid for 4 frames. Expect grant order 0,1,0,1 and src_id_out matching each frame.
3. Pause: stream_en_in toggled 0/1 every cycle during SHIFT. Expect exactly 32 read strobes, 63 cycles in SHIFT, and a correct serial word.
4. Timeout: register model never raises output_rdy. Expect err_out=1 after 15 cycles in WAIT_RDY, return to IDLE, and err_out still 1 on the next frame.
5. Reset mid-frame: rst_in=1 after the 10th read strobe. Expect all outputs 0 immediately (async). After release, req0 gets priority and a full 32-bit frame follows.
6. Register busy: reg_input_rdy_in held 0 with req1 valid. Expect no ack and busy_out=0 until input_rdy rises, then ack1 on the next edge.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the FP result/output-register path.
package fp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SHIFT_LEN = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    WAIT_RDY = 3'd2,
    SHIFT    = 3'd3,
    DRAIN    = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request found after the last grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand_c;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_c  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand_c = IDX_W'((32'(last_i) + i) % N);
      if (!valid_o && req_i[cand_c]) begin
        valid_o       = 1'b1;
        gnt_o[cand_c] = 1'b1;
        idx_o         = cand_c;
      end
    end
  end

endmodule

// File: rtl/fp_out_sched.sv
// Shares one serial output register between NUM_REQ result producers:
// grant, write, wait for output_rdy, issue 32 read strobes, wait for input_rdy.
module fp_out_sched
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned SRC_W        = 1,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [WORD_W*NUM_REQ-1:0] req_data_in,
  output logic [NUM_REQ-1:0]        req_ack_out,
  input  logic                      stream_en_in,
  input  logic                      reg_input_rdy_in,
  input  logic                      reg_output_rdy_in,
  output logic                      reg_wr_out,
  output logic [WORD_W-1:0]         reg_data_out,
  output logic                      reg_read_out,
  output logic [SRC_W-1:0]          src_id_out,
  output logic                      busy_out,
  output logic                      frame_done_out,
  output logic                      err_out
);

  localparam int unsigned TMO_W = $clog2(WAIT_TIMEOUT + 1);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt_c;
  logic [SRC_W-1:0]   gnt_idx_c;
  logic               gnt_any_c;
  logic [WORD_W-1:0]  gnt_word_c;

  logic               grant_c, tmo_hit_c, read_c, last_bit_c, drain_done_c;

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               wr_q, wr_d, done_q, done_d, err_q, err_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d, rr_q, rr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(SRC_W)) u_arb (
    .req_i   (req_valid_in),
    .last_i  (rr_q),
    .gnt_o   (gnt_c),
    .idx_o   (gnt_idx_c),
    .valid_o (gnt_any_c)
  );

  // One-hot grant selects the winning word.
  always_comb begin
    gnt_word_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_c[k]) gnt_word_c = gnt_word_c | req_data_in[k*WORD_W +: WORD_W];
    end
  end

  assign grant_c      = (state_q == IDLE) && reg_input_rdy_in && gnt_any_c;
  assign tmo_hit_c    = (state_q == WAIT_RDY) && !reg_output_rdy_in &&
                        (tmo_q == TMO_W'(WAIT_TIMEOUT - 1));
  assign read_c       = (state_q == SHIFT) && stream_en_in && (bit_cnt_q < CNT_W'(SHIFT_LEN));
  assign last_bit_c   = read_c && (bit_cnt_q == CNT_W'(SHIFT_LEN - 1));
  assign drain_done_c = (state_q == DRAIN) && reg_input_rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant_c) state_d = WRITE;
      WRITE:    state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (reg_output_rdy_in) state_d = SHIFT;
        else if (tmo_hit_c)    state_d = IDLE;
      end
      SHIFT:    if (last_bit_c) state_d = DRAIN;
      DRAIN:    if (drain_done_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Read strobe is combinational so a stream_en pause takes effect in the same cycle.
  always_comb begin
    reg_read_out = read_c;
    busy_out     = (state_q != IDLE);
  end

  always_comb begin
    ack_d     = '0;
    wr_d      = (state_q == WRITE);
    done_d    = drain_done_c;
    err_d     = err_q | tmo_hit_c;
    data_d    = data_q;
    src_d     = src_q;
    rr_d      = rr_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = '0;
    if (grant_c) begin
      ack_d  = gnt_c;
      data_d = gnt_word_c;
      src_d  = gnt_idx_c;
      rr_d   = gnt_idx_c;
    end
    case (state_q)
      WAIT_RDY: begin
        bit_cnt_d = '0;
        if (!reg_output_rdy_in && !tmo_hit_c) tmo_d = tmo_q + TMO_W'(1);
      end
      SHIFT:    if (read_c) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ack_q     <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      rr_q      <= SRC_W'(NUM_REQ - 1);
      bit_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      data_q    <= data_d;
      src_q     <= src_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req_ack_out    = ack_q;
  assign reg_wr_out     = wr_q;
  assign reg_data_out   = data_q;
  assign src_id_out     = src_q;
  assign frame_done_out = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_fp_out_sched.sv
// Directed + randomized bench for fp_out_sched with a behavioural serial output register.
module tb_fp_out_sched;

  localparam int N   = 2;
  localparam int TMO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic            stream_en, in_rdy, out_rdy, wr, rd, busy, done, err;
  logic [31:0]     rdata;
  logic [0:0]      src;

  always #5 clk = ~clk;

  fp_out_sched #(.NUM_REQ(N), .SRC_W(1), .WAIT_TIMEOUT(TMO)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .req_valid_in      (req_valid),
    .req_data_in       (req_data),
    .req_ack_out       (ack),
    .stream_en_in      (stream_en),
    .reg_input_rdy_in  (in_rdy),
    .reg_output_rdy_in (out_rdy),
    .reg_wr_out        (wr),
    .reg_data_out      (rdata),
    .reg_read_out      (rd),
    .src_id_out        (src),
    .busy_out          (busy),
    .frame_done_out    (done),
    .err_out           (err)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial output register: loads on wr, shifts LSB-first on each read strobe.
  logic        m_loaded = 1'b0;
  logic [31:0] m_sh = '0, m_rx = '0;
  int          m_cnt = 0, m_rx_n = 0, wr_while_busy = 0;
  bit          force_busy = 0, block_ordy = 0, flush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loaded <= 1'b0;
      m_cnt    <= 0;
    end else if (flush) begin
      m_loaded <= 1'b0;
      m_cnt    <= 0;
    end else if (wr) begin
      if (m_loaded) wr_while_busy <= wr_while_busy + 1;
      m_loaded <= 1'b1;
      m_sh     <= rdata;
      m_cnt    <= 32;
      m_rx     <= '0;
      m_rx_n   <= 0;
    end else if (rd && m_loaded && m_cnt > 0) begin
      m_sh         <= m_sh >> 1;
      m_rx[m_rx_n] <= m_sh[0];
      m_rx_n       <= m_rx_n + 1;
      m_cnt        <= m_cnt - 1;
      if (m_cnt == 1) m_loaded <= 1'b0;
    end
  end

  assign in_rdy  = !m_loaded && !force_busy;
  assign out_rdy = m_loaded && (m_cnt != 0) && !block_ordy;

  logic [31:0] words [N];
  int          last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int lst);
    for (int i = 1; i <= N; i++) if (mask[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  task automatic set_word(input int k, input logic [31:0] w);
    words[k] = w;
    req_data[k*32 +: 32] = w;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output int c);
    a = '0;
    c = -1;
    for (int i = 0; i < 60 && a == '0; i++) begin
      step();
      if (ack != '0) begin a = ack; c = cyc; end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},  32'(ack),   32'd0);
    chk({tag, "_wr"},   32'(wr),    32'd0);
    chk({tag, "_rd"},   32'(rd),    32'd0);
    chk({tag, "_busy"}, 32'(busy),  32'd0);
    chk({tag, "_done"}, 32'(done),  32'd0);
    chk({tag, "_err"},  32'(err),   32'd0);
    chk({tag, "_data"}, rdata,      32'd0);
    chk({tag, "_src"},  32'(src),   32'd0);
  endtask

  // en_mode: 0 always on, 1 toggle every cycle, 2 random
  task automatic run_frame(input int en_mode, output int reads, output int first_rd,
                           output int last_rd, output bit got_done, output int done_src);
    reads = 0; first_rd = -1; last_rd = -1; got_done = 0; done_src = -1;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(posedge clk); #1;
      if (en_mode == 1)      stream_en = ~stream_en;
      else if (en_mode == 2) stream_en = ($urandom_range(0, 3) != 0);
      else                   stream_en = 1'b1;
      #1;
      if (rd) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (done) begin got_done = 1; done_src = int'(src); end
    end
    stream_en = 1'b1;
  endtask

  // Grant the expected requester from mask, check ack/src/data, then shift a whole frame.
  task automatic full_frame(input string tag, input logic [N-1:0] mask, input int en_mode,
                            input bit drop_valid, input logic exp_err);
    logic [N-1:0] a;
    int c, reads, f, l, dsrc, g;
    bit gd;
    g = rr_pick(mask, last);
    req_valid = mask;
    wait_ack(a, c);
    chk({tag, "_ack"},  32'(a),     32'(1) << g);
    chk({tag, "_src"},  32'(src),   32'(g));
    chk({tag, "_data"}, rdata,      words[g]);
    last = g;
    if (drop_valid) req_valid = '0;
    run_frame(en_mode, reads, f, l, gd, dsrc);
    chk({tag, "_done"},  32'(gd),   32'd1);
    chk({tag, "_reads"}, 32'(reads), 32'd32);
    chk({tag, "_word"},  m_rx,      words[g]);
    chk({tag, "_dsrc"},  32'(dsrc), 32'(g));
    chk({tag, "_err"},   32'(err),  32'(exp_err));
  endtask

  initial begin
    logic [N-1:0] a;
    int c, ack_c, reads, f, l, dsrc, nrd;
    bit gd;

    rst = 1'b1; req_valid = '0; req_data = '0; stream_en = 1'b1;
    #3;
    check_all_zero("reset");
    step(); step();
    @(posedge clk); #1 rst = 1'b0; #1;
    last = N - 1;

    // Single requester, known word
    set_word(0, 32'h3F80_0000);
    req_valid = 2'b01;
    step();
    chk("t1_ack",  32'(ack),  32'h1);
    chk("t1_src",  32'(src),  32'h0);
    chk("t1_data", rdata,     32'h3F80_0000);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_wr0",  32'(wr),   32'h0);
    ack_c = cyc;
    last = 0;
    req_valid = '0;
    step();
    chk("t1_wr",   32'(wr),   32'h1);
    chk("t1_ack1", 32'(ack),  32'h0);
    step();
    chk("t1_wr1",  32'(wr),   32'h0);
    run_frame(0, reads, f, l, gd, dsrc);
    chk("t1_first_rd", 32'(f - ack_c), 32'd3);
    chk("t1_reads",    32'(reads),     32'd32);
    chk("t1_word",     m_rx,           32'h3F80_0000);
    chk("t1_done",     32'(gd),        32'd1);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle",       32'(busy), 32'd0);

    // Fairness: both requesters held valid for four frames
    for (int k = 0; k < N; k++) set_word(k, $urandom);
    for (int fr = 0; fr < 4; fr++) begin
      full_frame($sformatf("t2_f%0d", fr), 2'b11, 0, 0, 1'b0);
      set_word(last, $urandom);
    end
    req_valid = '0;

    // Stream pause: toggling stream_en stretches 32 strobes over 63 cycles
    set_word(0, $urandom);
    req_valid = 2'b01;
    wait_ack(a, c);
    chk("t3_ack", 32'(a), 32'(1) << rr_pick(2'b01, last));
    last = 0;
    req_valid = '0;
    run_frame(1, reads, f, l, gd, dsrc);
    chk("t3_reads", 32'(reads),     32'd32);
    chk("t3_span",  32'(l - f + 1), 32'd63);
    chk("t3_word",  m_rx,           words[0]);

    // Timeout: output_rdy never rises
    set_word(1, $urandom);
    block_ordy = 1;
    req_valid = 2'b10;
    wait_ack(a, c);
    chk("t4_ack", 32'(a), 32'(1) << rr_pick(2'b10, last));
    last = 1;
    req_valid = '0;
    nrd = 0;
    for (int i = 1; i <= TMO; i++) begin step(); if (rd) nrd++; end
    chk("t4_err_early", 32'(err),  32'd0);
    chk("t4_busy_early", 32'(busy), 32'd1);
    step();
    chk("t4_err",   32'(err),  32'd1);
    chk("t4_busy",  32'(busy), 32'd0);
    chk("t4_reads", 32'(nrd),  32'd0);
    block_ordy = 0;
    flush = 1; step(); flush = 0;
    set_word(0, $urandom);
    full_frame("t4_next", 2'b01, 0, 1, 1'b1);

    // Reset mid-frame after the 10th strobe
    set_word(0, $urandom);
    set_word(1, $urandom);
    req_valid = 2'b11;
    wait_ack(a, c);
    chk("t5_ack", 32'(a), 32'(1) << rr_pick(2'b11, last));
    nrd = 0;
    for (int i = 0; i < 200 && nrd < 10; i++) begin step(); if (rd) nrd++; end
    chk("t5_pre_reads", 32'(nrd), 32'd10);
    #1 rst = 1'b1; #1;
    check_all_zero("t5_rst");
    step();
    @(posedge clk); #1 rst = 1'b0; #1;
    last = N - 1;
    full_frame("t5_after", 2'b11, 0, 1, 1'b0);

    // Register not input-ready: no grant, stay idle
    set_word(1, $urandom);
    force_busy = 1;
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6_noack%0d", i),  32'(ack),  32'd0);
      chk($sformatf("t6_nobusy%0d", i), 32'(busy), 32'd0);
    end
    force_busy = 0;
    step();
    chk("t6_ack", 32'(ack), 32'(1) << rr_pick(2'b10, last));
    last = 1;
    req_valid = '0;
    run_frame(0, reads, f, l, gd, dsrc);
    chk("t6_reads", 32'(reads), 32'd32);
    chk("t6_word",  m_rx,       words[1]);

    // Random masks, words and stream_en; unacked requesters lose their turn
    for (int fr = 0; fr < 6; fr++) begin
      for (int k = 0; k < N; k++) set_word(k, $urandom);
      full_frame($sformatf("rnd%0d", fr), N'($urandom_range(1, 3)), 2, 1, 1'b0);
    end

    chk("no_wr_while_busy", 32'(wr_while_busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
